// File: rtl/llc_input_bufs.sv
// LLC input-buffer stage: 2-entry FIFOs on the four incoming LLC channels plus the
// current-request, stalled-request and current-DMA registers loaded by decoder strobes.
module llc_input_bufs #(
  parameter int unsigned LINE_ADDR_BITS = 28,
  parameter int unsigned LLC_SET_BITS   = 8,
  parameter int unsigned REQ_PL_BITS    = 16,
  parameter int unsigned RSP_PL_BITS    = 136,
  parameter int unsigned DMA_PL_BITS    = 136
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // NoC side
  input  logic                                   rst_tb_in_valid,
  output logic                                   rst_tb_in_ready,
  input  logic                                   rst_tb_in_flush,
  input  logic                                   rsp_in_valid,
  output logic                                   rsp_in_ready,
  input  logic [LINE_ADDR_BITS-1:0]              rsp_in_addr_i,
  input  logic [RSP_PL_BITS-1:0]                 rsp_in_pl_i,
  input  logic                                   req_in_valid,
  output logic                                   req_in_ready,
  input  logic [LINE_ADDR_BITS-1:0]              req_in_addr_i,
  input  logic [REQ_PL_BITS-1:0]                 req_in_pl_i,
  input  logic                                   dma_in_valid,
  output logic                                   dma_in_ready,
  input  logic [LINE_ADDR_BITS-1:0]              dma_in_addr_i,
  input  logic [DMA_PL_BITS-1:0]                 dma_in_pl_i,
  // Decoder side
  output logic                                   llc_rst_tb_valid,
  output logic                                   llc_rsp_in_valid,
  output logic                                   llc_req_in_valid,
  output logic                                   llc_dma_req_in_valid,
  output logic                                   rst_tb_flush,
  output logic [LINE_ADDR_BITS-1:0]              rsp_in_addr,
  output logic [RSP_PL_BITS-1:0]                 rsp_in_pl,
  output logic [LINE_ADDR_BITS-1:0]              dma_req_in_addr,
  output logic [LINE_ADDR_BITS-1:0]              req_in_addr,
  input  logic                                   pop_rst_tb,
  input  logic                                   pop_rsp,
  input  logic                                   do_get_req,
  input  logic                                   do_get_dma_req,
  input  logic                                   update_req_in_from_stalled,
  input  logic                                   clr_req_in_stalled_valid,
  input  logic                                   set_req_stalled,
  output logic [LINE_ADDR_BITS-1:0]              req_cur_addr,
  output logic [REQ_PL_BITS-1:0]                 req_cur_pl,
  output logic [LINE_ADDR_BITS-1:0]              dma_cur_addr,
  output logic [DMA_PL_BITS-1:0]                 dma_cur_pl,
  output logic                                   req_in_stalled_valid,
  output logic [LLC_SET_BITS-1:0]                req_in_stalled_set,
  output logic [LINE_ADDR_BITS-LLC_SET_BITS-1:0] req_in_stalled_tag,
  output logic                                   fifo_err
);

  // ---------------- rst_tb channel ----------------
  logic [1:0] rtb_cnt_q;
  logic       rtb_wp_q, rtb_rp_q;
  logic       rtb_mem_q [2];
  logic       rtb_push, rtb_pop;

  assign rst_tb_in_ready  = (rtb_cnt_q != 2'd2);
  assign llc_rst_tb_valid = (rtb_cnt_q != 2'd0);
  assign rtb_push         = rst_tb_in_valid & rst_tb_in_ready;
  assign rtb_pop          = pop_rst_tb & llc_rst_tb_valid;
  assign rst_tb_flush     = rtb_mem_q[rtb_rp_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rtb_cnt_q    <= 2'd0;
      rtb_wp_q     <= 1'b0;
      rtb_rp_q     <= 1'b0;
      rtb_mem_q[0] <= 1'b0;
      rtb_mem_q[1] <= 1'b0;
    end else begin
      if (rtb_push) begin
        rtb_mem_q[rtb_wp_q] <= rst_tb_in_flush;
        rtb_wp_q            <= ~rtb_wp_q;
      end
      if (rtb_pop) rtb_rp_q <= ~rtb_rp_q;
      rtb_cnt_q <= rtb_cnt_q + {1'b0, rtb_push} - {1'b0, rtb_pop};
    end
  end

  // ---------------- rsp channel ----------------
  logic [1:0]                rsp_cnt_q;
  logic                      rsp_wp_q, rsp_rp_q;
  logic [LINE_ADDR_BITS-1:0] rsp_addr_q [2];
  logic [RSP_PL_BITS-1:0]    rsp_pl_q   [2];
  logic                      rsp_push, rsp_pop;

  assign rsp_in_ready     = (rsp_cnt_q != 2'd2);
  assign llc_rsp_in_valid = (rsp_cnt_q != 2'd0);
  assign rsp_push         = rsp_in_valid & rsp_in_ready;
  assign rsp_pop          = pop_rsp & llc_rsp_in_valid;
  assign rsp_in_addr      = rsp_addr_q[rsp_rp_q];
  assign rsp_in_pl        = rsp_pl_q[rsp_rp_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_cnt_q <= 2'd0;
      rsp_wp_q  <= 1'b0;
      rsp_rp_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rsp_addr_q[i] <= '0;
        rsp_pl_q[i]   <= '0;
      end
    end else begin
      if (rsp_push) begin
        rsp_addr_q[rsp_wp_q] <= rsp_in_addr_i;
        rsp_pl_q[rsp_wp_q]   <= rsp_in_pl_i;
        rsp_wp_q             <= ~rsp_wp_q;
      end
      if (rsp_pop) rsp_rp_q <= ~rsp_rp_q;
      rsp_cnt_q <= rsp_cnt_q + {1'b0, rsp_push} - {1'b0, rsp_pop};
    end
  end

  // ---------------- req channel ----------------
  logic [1:0]                req_cnt_q;
  logic                      req_wp_q, req_rp_q;
  logic [LINE_ADDR_BITS-1:0] req_addr_q [2];
  logic [REQ_PL_BITS-1:0]    req_pl_q   [2];
  logic                      req_push, req_pop, req_get_conflict;

  // A stalled reload takes priority over a FIFO get; the FIFO is left untouched.
  assign req_get_conflict = do_get_req & update_req_in_from_stalled;
  assign req_in_ready     = (req_cnt_q != 2'd2);
  assign llc_req_in_valid = (req_cnt_q != 2'd0);
  assign req_push         = req_in_valid & req_in_ready;
  assign req_pop          = do_get_req & ~update_req_in_from_stalled & llc_req_in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cnt_q <= 2'd0;
      req_wp_q  <= 1'b0;
      req_rp_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        req_addr_q[i] <= '0;
        req_pl_q[i]   <= '0;
      end
    end else begin
      if (req_push) begin
        req_addr_q[req_wp_q] <= req_in_addr_i;
        req_pl_q[req_wp_q]   <= req_in_pl_i;
        req_wp_q             <= ~req_wp_q;
      end
      if (req_pop) req_rp_q <= ~req_rp_q;
      req_cnt_q <= req_cnt_q + {1'b0, req_push} - {1'b0, req_pop};
    end
  end

  // ---------------- dma channel ----------------
  logic [1:0]                dma_cnt_q;
  logic                      dma_wp_q, dma_rp_q;
  logic [LINE_ADDR_BITS-1:0] dma_addr_q [2];
  logic [DMA_PL_BITS-1:0]    dma_pl_q   [2];
  logic                      dma_push, dma_pop;

  assign dma_in_ready         = (dma_cnt_q != 2'd2);
  assign llc_dma_req_in_valid = (dma_cnt_q != 2'd0);
  assign dma_push             = dma_in_valid & dma_in_ready;
  assign dma_pop              = do_get_dma_req & llc_dma_req_in_valid;
  assign dma_req_in_addr      = dma_addr_q[dma_rp_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_cnt_q <= 2'd0;
      dma_wp_q  <= 1'b0;
      dma_rp_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dma_addr_q[i] <= '0;
        dma_pl_q[i]   <= '0;
      end
    end else begin
      if (dma_push) begin
        dma_addr_q[dma_wp_q] <= dma_in_addr_i;
        dma_pl_q[dma_wp_q]   <= dma_in_pl_i;
        dma_wp_q             <= ~dma_wp_q;
      end
      if (dma_pop) dma_rp_q <= ~dma_rp_q;
      dma_cnt_q <= dma_cnt_q + {1'b0, dma_push} - {1'b0, dma_pop};
    end
  end

  // ---------------- current / stalled registers ----------------
  logic [LINE_ADDR_BITS-1:0] req_cur_addr_q, stl_addr_q, dma_cur_addr_q;
  logic [REQ_PL_BITS-1:0]    req_cur_pl_q, stl_pl_q;
  logic [DMA_PL_BITS-1:0]    dma_cur_pl_q;
  logic                      stl_valid_q, err_q, err_set;

  assign err_set = (pop_rst_tb & ~llc_rst_tb_valid) | (pop_rsp & ~llc_rsp_in_valid) |
                   (do_get_dma_req & ~llc_dma_req_in_valid) | req_get_conflict |
                   (do_get_req & ~update_req_in_from_stalled & ~llc_req_in_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cur_addr_q <= '0;
      req_cur_pl_q   <= '0;
      stl_addr_q     <= '0;
      stl_pl_q       <= '0;
      stl_valid_q    <= 1'b0;
      dma_cur_addr_q <= '0;
      dma_cur_pl_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      if (update_req_in_from_stalled) begin
        req_cur_addr_q <= stl_addr_q;
        req_cur_pl_q   <= stl_pl_q;
      end else if (req_pop) begin
        req_cur_addr_q <= req_addr_q[req_rp_q];
        req_cur_pl_q   <= req_pl_q[req_rp_q];
      end
      if (set_req_stalled) begin
        stl_addr_q  <= req_cur_addr_q;
        stl_pl_q    <= req_cur_pl_q;
        stl_valid_q <= 1'b1;
      end else if (clr_req_in_stalled_valid) begin
        stl_valid_q <= 1'b0;
      end
      if (dma_pop) begin
        dma_cur_addr_q <= dma_addr_q[dma_rp_q];
        dma_cur_pl_q   <= dma_pl_q[dma_rp_q];
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign req_in_addr          = stl_valid_q ? stl_addr_q : req_addr_q[req_rp_q];
  assign req_cur_addr         = req_cur_addr_q;
  assign req_cur_pl           = req_cur_pl_q;
  assign dma_cur_addr         = dma_cur_addr_q;
  assign dma_cur_pl           = dma_cur_pl_q;
  assign req_in_stalled_valid = stl_valid_q;
  assign req_in_stalled_set   = stl_addr_q[LLC_SET_BITS-1:0];
  assign req_in_stalled_tag   = stl_addr_q[LINE_ADDR_BITS-1:LLC_SET_BITS];
  assign fifo_err             = err_q;

endmodule

// File: tb/tb_llc_input_bufs.sv
// Scoreboard bench for llc_input_bufs: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT.
module tb_llc_input_bufs;
  localparam int LA = 28, SB = 8, RQ = 16, RS = 136, DM = 136;

  logic clk, rst;
  logic rst_tb_in_valid, rst_tb_in_ready, rst_tb_in_flush;
  logic rsp_in_valid, rsp_in_ready, req_in_valid, req_in_ready, dma_in_valid, dma_in_ready;
  logic [LA-1:0] rsp_in_addr_i, req_in_addr_i, dma_in_addr_i;
  logic [RS-1:0] rsp_in_pl_i;
  logic [RQ-1:0] req_in_pl_i;
  logic [DM-1:0] dma_in_pl_i;
  logic llc_rst_tb_valid, llc_rsp_in_valid, llc_req_in_valid, llc_dma_req_in_valid;
  logic rst_tb_flush;
  logic [LA-1:0] rsp_in_addr, dma_req_in_addr, req_in_addr, req_cur_addr, dma_cur_addr;
  logic [RS-1:0] rsp_in_pl;
  logic [RQ-1:0] req_cur_pl;
  logic [DM-1:0] dma_cur_pl;
  logic pop_rst_tb, pop_rsp, do_get_req, do_get_dma_req;
  logic update_req_in_from_stalled, clr_req_in_stalled_valid, set_req_stalled;
  logic req_in_stalled_valid, fifo_err;
  logic [SB-1:0] req_in_stalled_set;
  logic [LA-SB-1:0] req_in_stalled_tag;

  llc_input_bufs #(
    .LINE_ADDR_BITS(LA), .LLC_SET_BITS(SB), .REQ_PL_BITS(RQ), .RSP_PL_BITS(RS),
    .DMA_PL_BITS(DM)
  ) dut (
    .clk(clk), .rst(rst),
    .rst_tb_in_valid(rst_tb_in_valid), .rst_tb_in_ready(rst_tb_in_ready),
    .rst_tb_in_flush(rst_tb_in_flush),
    .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready),
    .rsp_in_addr_i(rsp_in_addr_i), .rsp_in_pl_i(rsp_in_pl_i),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
    .req_in_addr_i(req_in_addr_i), .req_in_pl_i(req_in_pl_i),
    .dma_in_valid(dma_in_valid), .dma_in_ready(dma_in_ready),
    .dma_in_addr_i(dma_in_addr_i), .dma_in_pl_i(dma_in_pl_i),
    .llc_rst_tb_valid(llc_rst_tb_valid), .llc_rsp_in_valid(llc_rsp_in_valid),
    .llc_req_in_valid(llc_req_in_valid), .llc_dma_req_in_valid(llc_dma_req_in_valid),
    .rst_tb_flush(rst_tb_flush), .rsp_in_addr(rsp_in_addr), .rsp_in_pl(rsp_in_pl),
    .dma_req_in_addr(dma_req_in_addr), .req_in_addr(req_in_addr),
    .pop_rst_tb(pop_rst_tb), .pop_rsp(pop_rsp), .do_get_req(do_get_req),
    .do_get_dma_req(do_get_dma_req),
    .update_req_in_from_stalled(update_req_in_from_stalled),
    .clr_req_in_stalled_valid(clr_req_in_stalled_valid), .set_req_stalled(set_req_stalled),
    .req_cur_addr(req_cur_addr), .req_cur_pl(req_cur_pl),
    .dma_cur_addr(dma_cur_addr), .dma_cur_pl(dma_cur_pl),
    .req_in_stalled_valid(req_in_stalled_valid), .req_in_stalled_set(req_in_stalled_set),
    .req_in_stalled_tag(req_in_stalled_tag), .fifo_err(fifo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int SRtbV = 0, SRtbR = 1, SRtbF = 2, SRspV = 3, SRspR = 4, SRspA = 5;
  localparam int SReqV = 6, SReqR = 7, SReqA = 8, SReqCur = 9, SStlV = 10, SStlSet = 11;
  localparam int SStlTag = 12, SDmaV = 13, SDmaR = 14, SDmaA = 15, SDmaCur = 16, SErr = 17;
  localparam int SReqCurPl = 18;

  typedef struct {
    int          sel;
    logic [63:0] val;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  exp_t          exp_q[$];
  logic [LA-1:0] rsp_sb[$];
  exp_t          mon_e;

  function automatic logic [63:0] sig(input int s);
    case (s)
      SRtbV:     return 64'(llc_rst_tb_valid);
      SRtbR:     return 64'(rst_tb_in_ready);
      SRtbF:     return 64'(rst_tb_flush);
      SRspV:     return 64'(llc_rsp_in_valid);
      SRspR:     return 64'(rsp_in_ready);
      SRspA:     return 64'(rsp_in_addr);
      SReqV:     return 64'(llc_req_in_valid);
      SReqR:     return 64'(req_in_ready);
      SReqA:     return 64'(req_in_addr);
      SReqCur:   return 64'(req_cur_addr);
      SStlV:     return 64'(req_in_stalled_valid);
      SStlSet:   return 64'(req_in_stalled_set);
      SStlTag:   return 64'(req_in_stalled_tag);
      SDmaV:     return 64'(llc_dma_req_in_valid);
      SDmaR:     return 64'(dma_in_ready);
      SDmaA:     return 64'(dma_req_in_addr);
      SDmaCur:   return 64'(dma_cur_addr);
      SErr:      return 64'(fifo_err);
      SReqCurPl: return 64'(req_cur_pl);
      default:   return 64'hdead;
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      SRtbV:     return "llc_rst_tb_valid";
      SRtbR:     return "rst_tb_in_ready";
      SRtbF:     return "rst_tb_flush";
      SRspV:     return "llc_rsp_in_valid";
      SRspR:     return "rsp_in_ready";
      SRspA:     return "rsp_in_addr";
      SReqV:     return "llc_req_in_valid";
      SReqR:     return "req_in_ready";
      SReqA:     return "req_in_addr";
      SReqCur:   return "req_cur_addr";
      SStlV:     return "req_in_stalled_valid";
      SStlSet:   return "req_in_stalled_set";
      SStlTag:   return "req_in_stalled_tag";
      SDmaV:     return "llc_dma_req_in_valid";
      SDmaR:     return "dma_in_ready";
      SDmaA:     return "dma_req_in_addr";
      SDmaCur:   return "dma_cur_addr";
      SErr:      return "fifo_err";
      SReqCurPl: return "req_cur_pl";
      default:   return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic ex(input int s, input logic [63:0] v);
    exp_q.push_back('{sel: s, val: v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: queued expectations describe the state seen before the next edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(sname(mon_e.sel), sig(mon_e.sel), mon_e.val);
    end
    if (pop_rsp && llc_rsp_in_valid) begin
      if (rsp_sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_pop_unexpected: got=%0h expected=none", rsp_in_addr);
      end else begin
        chk("rsp_pop_head", 64'(rsp_in_addr), 64'(rsp_sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [LA-1:0] A1 = 28'h0000A01, A2 = 28'h0000A02;
  localparam logic [LA-1:0] A3 = 28'h0000A03, A4 = 28'h0000A04;

  initial begin
    rst = 1'b0;
    {rst_tb_in_valid, rst_tb_in_flush, rsp_in_valid, req_in_valid, dma_in_valid} = '0;
    {pop_rst_tb, pop_rsp, do_get_req, do_get_dma_req} = '0;
    {update_req_in_from_stalled, clr_req_in_stalled_valid, set_req_stalled} = '0;
    rsp_in_addr_i = '0; req_in_addr_i = '0; dma_in_addr_i = '0;
    rsp_in_pl_i = '0; req_in_pl_i = '0; dma_in_pl_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    ex(SRtbV, 0); ex(SRspV, 0); ex(SReqV, 0); ex(SDmaV, 0);
    ex(SRtbR, 1); ex(SRspR, 1); ex(SReqR, 1); ex(SDmaR, 1);
    ex(SErr, 0); ex(SStlV, 0); ex(SReqA, 0); ex(SReqCur, 0);

    // Single req push: valid appears only after the edge
    req_in_valid = 1; req_in_addr_i = 28'h0000123; req_in_pl_i = 16'h1111;
    ex(SReqV, 0); cyc();
    req_in_valid = 0; do_get_req = 1;
    ex(SReqV, 1); ex(SReqA, 28'h0000123); ex(SReqR, 1); cyc();
    do_get_req = 0;
    ex(SReqCur, 28'h0000123); ex(SReqV, 0); ex(SErr, 0);

    // rsp fill to 2, third held, then drain through the scoreboard
    rsp_in_valid = 1; rsp_in_addr_i = A1; rsp_in_pl_i = 136'hAA01; rsp_sb.push_back(A1);
    ex(SRspV, 0); cyc();
    rsp_in_addr_i = A2; rsp_sb.push_back(A2);
    ex(SRspV, 1); ex(SRspR, 1); ex(SRspA, A1); cyc();
    rsp_in_addr_i = A3;
    ex(SRspR, 0); ex(SRspA, A1); cyc();
    pop_rsp = 1;
    ex(SRspR, 0); cyc();
    pop_rsp = 0; rsp_sb.push_back(A3);
    ex(SRspR, 1); ex(SRspA, A2); cyc();
    rsp_in_valid = 0; pop_rsp = 1;
    ex(SRspR, 0); cyc();
    // count 1 with push and pop together
    rsp_in_valid = 1; rsp_in_addr_i = A4; rsp_sb.push_back(A4);
    ex(SRspV, 1); cyc();
    rsp_in_valid = 0; pop_rsp = 0;
    ex(SRspV, 1); ex(SRspA, A4); ex(SRspR, 1); cyc();
    pop_rsp = 1; cyc();
    pop_rsp = 0;
    ex(SRspV, 0); ex(SErr, 0);

    // req get, stall, and stalled address override
    req_in_valid = 1; req_in_addr_i = 28'h0ABCDEF; req_in_pl_i = 16'h2222; cyc();
    req_in_valid = 0; do_get_req = 1;
    ex(SReqA, 28'h0ABCDEF); cyc();
    do_get_req = 0; set_req_stalled = 1;
    req_in_valid = 1; req_in_addr_i = 28'h0000999; req_in_pl_i = 16'h3333;
    ex(SReqCur, 28'h0ABCDEF); cyc();
    set_req_stalled = 0; do_get_req = 1;
    req_in_addr_i = 28'h0000111; req_in_pl_i = 16'h4444;
    ex(SStlV, 1); ex(SStlSet, 8'hEF); ex(SStlTag, 20'h0ABCD);
    ex(SReqA, 28'h0ABCDEF); ex(SReqV, 1); cyc();
    req_in_valid = 0; do_get_req = 0;
    update_req_in_from_stalled = 1; clr_req_in_stalled_valid = 1;
    ex(SReqCur, 28'h0000999); ex(SReqCurPl, 16'h3333); ex(SReqA, 28'h0ABCDEF);
    ex(SReqV, 1); cyc();
    update_req_in_from_stalled = 0; clr_req_in_stalled_valid = 0;
    ex(SReqCur, 28'h0ABCDEF); ex(SReqCurPl, 16'h2222); ex(SStlV, 0);
    ex(SReqA, 28'h0000111); ex(SErr, 0);

    // Conflicting get + update: stalled wins, no pop, error flagged
    do_get_req = 1; update_req_in_from_stalled = 1; cyc();
    do_get_req = 0; update_req_in_from_stalled = 0;
    ex(SErr, 1); ex(SReqV, 1); ex(SReqA, 28'h0000111); cyc();

    // Asynchronous reset mid-stream, observed before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("async_rst req_valid", 64'(llc_req_in_valid), 0);
    chk("async_rst rsp_valid", 64'(llc_rsp_in_valid), 0);
    chk("async_rst fifo_err", 64'(fifo_err), 0);
    chk("async_rst req_cur_addr", 64'(req_cur_addr), 0);
    chk("async_rst req_ready", 64'(req_in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Pop on empty rst_tb sets a sticky error
    pop_rst_tb = 1;
    ex(SErr, 0); ex(SReqV, 0); cyc();
    pop_rst_tb = 0; rst_tb_in_valid = 1; rst_tb_in_flush = 1;
    ex(SErr, 1); cyc();
    rst_tb_in_valid = 0; pop_rst_tb = 1;
    ex(SRtbV, 1); ex(SRtbF, 1); ex(SErr, 1); cyc();
    pop_rst_tb = 0;
    ex(SRtbV, 0); ex(SErr, 1);

    // DMA get
    dma_in_valid = 1; dma_in_addr_i = 28'h0DDDDDD; dma_in_pl_i = 136'h55; cyc();
    dma_in_valid = 0; do_get_dma_req = 1;
    ex(SDmaV, 1); ex(SDmaA, 28'h0DDDDDD); cyc();
    do_get_dma_req = 0;
    ex(SDmaCur, 28'h0DDDDDD); ex(SDmaV, 0); ex(SDmaR, 1); cyc();

    chk("rsp_sb_drained", 64'(rsp_sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llc_input_bufs.md
# llc_input_bufs

LLC input-buffer stage that sits directly upstream of the LLC input decoder. It terminates the four incoming LLC channels (reset/flush command, coherence response, coherence request, DMA request) with 2-entry FIFOs. It presents valid/head-address views to the decoder and holds the current-request, stalled-request and current-DMA registers that the decoder's get/update strobes load.

## Interface
- LINE_ADDR_BITS, 28: line address width.
- LLC_SET_BITS, 8: set index width; tag = LINE_ADDR_BITS-LLC_SET_BITS.
- REQ_PL_BITS, 16: opaque request payload (msg, hprot, id).
- RSP_PL_BITS, 136: opaque response payload (msg, line data).
- DMA_PL_BITS, 136: opaque DMA payload.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- {rst_tb,rsp,req,dma}_in_valid  in  1 each  NoC-side push valid.
- {rst_tb,rsp,req,dma}_in_ready  out  1 each  NoC-side ready = FIFO count<2.
- rst_tb_in_flush  in  1  rst_tb payload (1 = flush, 0 = reset).
- rsp/req/dma_in_addr_i  in  LINE_ADDR_BITS  line address per channel.
- rsp/req/dma_in_pl_i  in  *_PL_BITS  payload per channel.
- llc_rst_tb_valid, llc_rsp_in_valid, llc_req_in_valid, llc_dma_req_in_valid  out  1  FIFO non-empty.
- rst_tb_flush  out  1  head of rst_tb FIFO.
- rsp_in_addr, rsp_in_pl  out  LINE_ADDR_BITS/RSP_PL_BITS  head of rsp FIFO.
- dma_req_in_addr  out  LINE_ADDR_BITS  head of dma FIFO.
- req_in_addr  out  LINE_ADDR_BITS  req_in_stalled_valid ? stalled addr : req FIFO head addr.
- pop_rst_tb, pop_rsp  in  1  consume head (from decoder's registered is_*_to_get).
- do_get_req, do_get_dma_req  in  1  pop head into current register.
- update_req_in_from_stalled, clr_req_in_stalled_valid  in  1  decoder strobes.
- set_req_stalled  in  1  later stage parks current request.
- req_cur_addr/pl, dma_cur_addr/pl  out  registered current request / DMA.
- req_in_stalled_valid  out  1; req_in_stalled_set  out  LLC_SET_BITS; req_in_stalled_tag  out  tag width.
- fifo_err  out  1  sticky: pop on empty or conflicting strobes.

## Operation
- Each channel: 2-entry FIFO, write/read pointers (1 bit) plus count (0..2). Push = in_valid & in_ready. Pop = respective pop/do_get strobe.
- Push and pop in the same cycle with count 1: count stays 1, head advances to the pushed entry. With count 0: no bypass; push lands, pop is illegal.
- Pop when count==0: no state change, set fifo_err.
- do_get_req: req_cur <= req head, pop req FIFO. update_req_in_from_stalled: req_cur <= stalled contents. Both asserted: stalled wins, no pop, fifo_err set.
- do_get_dma_req: dma_cur <= dma head, pop dma FIFO.
- set_req_stalled: stalled <= req_cur, req_in_stalled_valid <= 1. clr_req_in_stalled_valid: valid <= 0. Both asserted: set wins.
- Stalled set/tag are the low LLC_SET_BITS / upper bits of stalled addr.
- fifo_err clears only on reset.

## Timing
- Reset (async, rst=0): all counts 0, all pointers 0, all storage and current/stalled registers 0, req_in_stalled_valid 0, fifo_err 0. Hence all llc_*_valid=0, all *_in_ready=1, head outputs 0. Reset mid-operation discards buffered entries.
- Push-to-visible latency: 1 cycle (valid rises on the clock edge after push). No combinational in_valid→llc_*_valid path.
- Ready depends only on registered count, not on same-cycle pop.
- Head outputs are combinational from storage/read pointer. Current/stalled registers update on the strobe edge.

## Test plan
- Reset then push req addr 0x0000123 -> llc_req_in_valid=1 next cycle, req_in_addr=0x0000123, req_in_ready stays 1.
- Push 3 rsp back-to-back with no pop -> ready drops after 2nd push; 3rd held; pop_rsp -> ready=1 next cycle, head = 2nd address.
- Count 1 with simultaneous push and pop_rsp -> count stays 1, head = new address, valid never drops.
- do_get_req on head 0x0ABCDEF, then set_req_stalled -> stalled_valid=1, set=0xEF, tag=0x0ABCD, req_in_addr=0x0ABCDEF even after new FIFO head 0x0000111.
- update_req_in_from_stalled with clr_req_in_stalled_valid -> req_cur = 0x0ABCDEF, stalled_valid=0, req_in_addr = FIFO head 0x0000111.
- pop_rst_tb on empty -> fifo_err=1 sticky. Assert rst low mid-stream -> all valids 0 and fifo_err 0 immediately, without waiting for a clock edge.
